// File: rtl/rs_ap_ctrl_pkg.sv
// Shared types and defaults for the ap_ctrl relay pipelines (start/ready and done/continue paths).
package rs_ap_ctrl_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } rs_relay_state_e;

  localparam int RS_DEFAULT_BODY_LEVEL = 6;

  // Cycles after reset during which head and tail are held inert.
  function automatic int rs_grace(input int level);
    return level * 2;
  endfunction

endpackage

// File: rtl/rs_ap_ctrl_relay_stage.sv
// One 2-entry relay stage for a payload-less token: occupancy is the storage, ready is registered.
module rs_ap_ctrl_relay_stage
  import rs_ap_ctrl_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_valid,
  output logic o_ready,
  output logic o_valid,
  input  logic i_ready
);

  rs_relay_state_e r_state;
  rs_relay_state_e w_state_nxt;
  logic            r_ready;
  logic            w_push;
  logic            w_pop;

  assign o_valid = (r_state != EMPTY);
  assign o_ready = r_ready;
  assign w_push  = i_valid & r_ready;
  assign w_pop   = o_valid & i_ready;

  // NOTE: w_state_nxt gets a default before the case, so no branch can leave it unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EMPTY: if (w_push) w_state_nxt = ONE;
      ONE: begin
        if (w_push && !w_pop)      w_state_nxt = FULL;
        else if (!w_push && w_pop) w_state_nxt = EMPTY;
      end
      // Push is impossible while FULL because the registered ready is low.
      FULL:    if (w_pop) w_state_nxt = ONE;
      default: w_state_nxt = EMPTY;
    endcase
  end

  // NOTE: flops use non-blocking assignments so every register samples the pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= EMPTY;
      r_ready <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= (w_state_nxt != FULL);
    end
  end

endmodule

// File: rtl/rs_ap_ctrl_done_continue_pipeline.sv
// Relays kernel ap_done tokens to the host side through BODY_LEVEL stages and returns ap_continue.
module rs_ap_ctrl_done_continue_pipeline
  import rs_ap_ctrl_pkg::*;
#(
  parameter int BODY_LEVEL   = RS_DEFAULT_BODY_LEVEL,
  parameter int GRACE_PERIOD = rs_grace(BODY_LEVEL),
  parameter int CNT_W        = $clog2(2 * BODY_LEVEL + 3)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             if_ap_done,
  output logic             if_ap_continue,
  output logic             of_ap_done,
  input  logic             of_ap_continue,
  output logic [CNT_W-1:0] in_flight,
  output logic             pipe_empty
);

  localparam int GRACE_W = (GRACE_PERIOD > 0) ? $clog2(GRACE_PERIOD + 1) : 1;

  logic [GRACE_W-1:0] r_grace_cnt;
  logic               r_head_valid;
  logic               r_tail_valid;
  logic [CNT_W-1:0]   r_in_flight;
  logic               w_grace_done;
  logic               w_capture;
  logic               w_pop;
  logic               w_tail_load;
  // Index 0 is the head side; index BODY_LEVEL is the tail-gate side.
  logic [BODY_LEVEL:0] w_valid;
  logic [BODY_LEVEL:0] w_ready;

  assign w_grace_done = (r_grace_cnt == '0);
  // Gating with reset keeps continue low even before the first reset edge has loaded the grace counter.
  assign w_capture    = if_ap_done & ~r_head_valid & w_grace_done & ~reset;
  assign of_ap_done   = r_tail_valid & w_grace_done;
  assign w_pop        = of_ap_done & of_ap_continue;

  assign if_ap_continue = w_capture;
  assign in_flight      = r_in_flight;
  assign pipe_empty     = (r_in_flight == '0) & w_grace_done;

  assign w_valid[0]          = r_head_valid;
  assign w_ready[BODY_LEVEL] = ~r_tail_valid | w_pop;
  assign w_tail_load         = w_valid[BODY_LEVEL] & w_ready[BODY_LEVEL];

  for (genvar g = 0; g < BODY_LEVEL; g++) begin : g_body
    rs_ap_ctrl_relay_stage u_stage (
      .clk     (clk),
      .reset   (reset),
      .i_valid (w_valid[g]),
      .o_ready (w_ready[g]),
      .o_valid (w_valid[g+1]),
      .i_ready (w_ready[g+1])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_grace_cnt <= GRACE_W'(GRACE_PERIOD);
    end else if (!w_grace_done) begin
      r_grace_cnt <= r_grace_cnt - GRACE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head_valid <= 1'b0;
    end else if (w_capture) begin
      r_head_valid <= 1'b1;
    end else if (r_head_valid && w_ready[0]) begin
      r_head_valid <= 1'b0;
    end
  end

  // Reload takes priority so a pop and a refill in one cycle keep the gate occupied.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tail_valid <= 1'b0;
    end else if (w_tail_load) begin
      r_tail_valid <= 1'b1;
    end else if (w_pop) begin
      r_tail_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_in_flight <= '0;
    end else if (w_capture && !w_pop) begin
      r_in_flight <= r_in_flight + CNT_W'(1);
    end else if (!w_capture && w_pop) begin
      r_in_flight <= r_in_flight - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_rs_ap_ctrl_done_continue_pipeline.sv
// Self-checking bench: directed grace/latency/capacity/reset steps plus a randomized token stream.
module tb_rs_ap_ctrl_done_continue_pipeline;

  localparam int BL       = 6;
  localparam int GP       = 2 * BL;
  localparam int CAPACITY = 2 * BL + 2;
  localparam int LAT      = BL + 2;
  localparam int CNT_W    = $clog2(2 * BL + 3);

  logic             clk = 1'b0;
  logic             reset;
  logic             if_ap_done;
  logic             if_ap_continue;
  logic             of_ap_done;
  logic             of_ap_continue;
  logic [CNT_W-1:0] in_flight;
  logic             pipe_empty;

  always #5 clk = ~clk;

  rs_ap_ctrl_done_continue_pipeline #(
    .BODY_LEVEL   (BL),
    .GRACE_PERIOD (GP),
    .CNT_W        (CNT_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .if_ap_done     (if_ap_done),
    .if_ap_continue (if_ap_continue),
    .of_ap_done     (of_ap_done),
    .of_ap_continue (of_ap_continue),
    .in_flight      (in_flight),
    .pipe_empty     (pipe_empty)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: token count, grace countdown and capture timestamps of queued tokens.
  int cyc         = 0;
  bit model_valid = 1'b0;
  int model_cnt   = 0;
  int model_grace = GP;
  int cap_q[$];

  // Kernel model state.
  int issue_left = 0;
  int gap        = 0;
  int gap_max    = 0;
  bit rand_cont  = 1'b0;
  int caps_tot   = 0;
  int pops_tot   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic settle();
    #1;
  endtask

  // Samples handshakes before the edge, advances one clock, updates the model and checks the counters.
  task automatic step(output bit cap, output bit pop, output bit od);
    #1;
    cap = if_ap_continue;
    od  = of_ap_done;
    pop = od & of_ap_continue;
    if (reset) check("continue_in_reset", 32'(if_ap_continue), 0);
    if (model_valid && model_grace != 0) begin
      check("continue_in_grace", 32'(if_ap_continue), 0);
      check("done_in_grace", 32'(of_ap_done), 0);
    end
    if (cap) begin
      check("capture_has_room", 32'(model_cnt < CAPACITY), 1);
      check("capture_needs_done", 32'(if_ap_done), 1);
    end
    if (od && !reset) check("done_has_token", 32'(model_cnt > 0), 1);
    @(posedge clk);
    cyc++;
    if (reset) begin
      model_valid = 1'b1;
      model_cnt   = 0;
      model_grace = GP;
      cap_q.delete();
    end else begin
      if (model_grace > 0) model_grace--;
      if (cap) cap_q.push_back(cyc - 1);
      if (pop) begin
        check("pop_has_token", 32'(cap_q.size() > 0), 1);
        if (cap_q.size() > 0) begin
          check("min_latency", 32'(((cyc - 1) - cap_q[0]) >= LAT), 1);
          void'(cap_q.pop_front());
        end
      end
      model_cnt = model_cnt + int'(cap) - int'(pop);
    end
    #1;
    if (model_valid) begin
      check("in_flight", 32'(in_flight), 32'(model_cnt));
      check("pipe_empty", 32'(pipe_empty), 32'(model_cnt == 0 && model_grace == 0));
    end
  endtask

  // One cycle with the kernel model: done held until continue, then dropped for at least one cycle.
  task automatic kcycle(output bit cap, output bit pop, output bit od);
    step(cap, pop, od);
    if (cap) begin
      caps_tot++;
      if (issue_left > 0) issue_left--;
      gap = 2 + int'($urandom_range(gap_max, 0));
    end
    if (pop) pops_tot++;
    if (gap > 0) gap--;
    if_ap_done = (issue_left > 0) && (gap == 0);
    if (rand_cont) of_ap_continue = 1'($urandom_range(1, 0));
  endtask

  initial begin
    bit cap, pop, od;
    int first_cap, first_od, od_cnt, cap_cnt;
    int base_caps, base_pops, budget;

    // Reset with done already held.
    reset = 1'b1; if_ap_done = 1'b1; of_ap_continue = 1'b1;
    issue_left = 1; gap = 0; gap_max = 0; rand_cont = 1'b0;
    repeat (2) kcycle(cap, pop, od);
    settle();
    check("rst_in_flight", 32'(in_flight), 0);
    check("rst_of_ap_done", 32'(of_ap_done), 0);
    check("rst_pipe_empty", 32'(pipe_empty), 0);
    check("rst_if_ap_continue", 32'(if_ap_continue), 0);

    // Grace: capture at cycle 12, host done at cycle 20.
    reset = 1'b0;
    first_cap = -1; first_od = -1; od_cnt = 0; cap_cnt = 0;
    for (int k = 0; k < 30; k++) begin
      kcycle(cap, pop, od);
      if (cap) begin cap_cnt++; if (first_cap < 0) first_cap = k; end
      if (od) begin od_cnt++; if (first_od < 0) first_od = k; end
    end
    check("grace_capture_cycle", 32'(first_cap), GP);
    check("grace_done_cycle", 32'(first_od), GP + LAT);
    check("grace_single_capture", 32'(cap_cnt), 1);
    check("grace_done_pulse_len", 32'(od_cnt), 1);

    // Single token with continue tied high.
    issue_left = 1; gap = 0; if_ap_done = 1'b1;
    first_cap = -1; first_od = -1; od_cnt = 0; cap_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      kcycle(cap, pop, od);
      if (cap) begin
        cap_cnt++;
        if (first_cap < 0) first_cap = k;
        settle();
        check("single_in_flight_1", 32'(in_flight), 1);
      end
      if (od) begin od_cnt++; if (first_od < 0) first_od = k; end
    end
    check("single_capture_cycle", 32'(first_cap), 0);
    check("single_capture_count", 32'(cap_cnt), 1);
    check("single_done_count", 32'(od_cnt), 1);
    check("single_latency", 32'(first_od - first_cap), LAT);
    settle();
    check("single_in_flight_0", 32'(in_flight), 0);

    // Back-pressure: fill to capacity, then drain.
    of_ap_continue = 1'b0; issue_left = 20; gap = 0; if_ap_done = 1'b1;
    base_caps = caps_tot; base_pops = pops_tot;
    repeat (80) kcycle(cap, pop, od);
    settle();
    check("bp_captures", 32'(caps_tot - base_caps), CAPACITY);
    check("bp_in_flight", 32'(in_flight), CAPACITY);
    check("bp_done_held", 32'(if_ap_done), 1);
    check("bp_continue_stalled", 32'(if_ap_continue), 0);
    of_ap_continue = 1'b1;
    repeat (CAPACITY) kcycle(cap, pop, od);
    check("bp_burst_pops", 32'(pops_tot - base_pops), CAPACITY);
    budget = 0;
    while ((pops_tot - base_pops) < 20 && budget < 300) begin
      kcycle(cap, pop, od);
      budget++;
    end
    check("bp_total_captures", 32'(caps_tot - base_caps), 20);
    check("bp_total_pops", 32'(pops_tot - base_pops), 20);

    // Randomized stream: 1000 tokens, random gaps and 50% host continue.
    rand_cont = 1'b1; gap_max = 3; issue_left = 1000; gap = 0; if_ap_done = 1'b1;
    base_caps = caps_tot; base_pops = pops_tot;
    budget = 0;
    while ((issue_left > 0 || model_cnt > 0) && budget < 40000) begin
      kcycle(cap, pop, od);
      budget++;
    end
    check("rand_budget", 32'(budget < 40000), 1);
    check("rand_captures", 32'(caps_tot - base_caps), 1000);
    check("rand_pops", 32'(pops_tot - base_pops), 1000);
    settle();
    check("rand_in_flight_0", 32'(in_flight), 0);
    rand_cont = 1'b0; gap_max = 0;

    // Reset with nine tokens in flight.
    of_ap_continue = 1'b0; issue_left = 9; gap = 0; if_ap_done = 1'b1;
    repeat (40) kcycle(cap, pop, od);
    settle();
    check("rst_mid_in_flight_9", 32'(in_flight), 9);
    check("rst_mid_done_before", 32'(of_ap_done), 1);
    reset = 1'b1; issue_left = 0; if_ap_done = 1'b0;
    kcycle(cap, pop, od);
    settle();
    check("rst_mid_done_after", 32'(of_ap_done), 0);
    check("rst_mid_in_flight_0", 32'(in_flight), 0);
    check("rst_mid_pipe_empty", 32'(pipe_empty), 0);
    reset = 1'b0; issue_left = 1; gap = 0; if_ap_done = 1'b1; of_ap_continue = 1'b1;
    first_cap = -1; first_od = -1;
    for (int k = 0; k < 30; k++) begin
      kcycle(cap, pop, od);
      if (cap && first_cap < 0) first_cap = k;
      if (od && first_od < 0) first_od = k;
    end
    check("rst_mid_grace_capture", 32'(first_cap), GP);
    check("rst_mid_grace_done", 32'(first_od), GP + LAT);

    // Capture and pop in the same cycle with three tokens held.
    of_ap_continue = 1'b0; issue_left = 3; gap = 0; if_ap_done = 1'b1;
    repeat (30) kcycle(cap, pop, od);
    settle();
    check("same_pre_in_flight", 32'(in_flight), 3);
    check("same_pre_done", 32'(of_ap_done), 1);
    if_ap_done = 1'b1; of_ap_continue = 1'b1;
    step(cap, pop, od);
    check("same_cycle_capture", 32'(cap), 1);
    check("same_cycle_pop", 32'(pop), 1);
    if_ap_done = 1'b0; of_ap_continue = 1'b0;
    settle();
    check("same_cycle_in_flight", 32'(in_flight), 3);
    of_ap_continue = 1'b1; issue_left = 0;
    repeat (30) kcycle(cap, pop, od);
    settle();
    check("final_in_flight", 32'(in_flight), 0);
    check("final_pipe_empty", 32'(pipe_empty), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
